// File: rtl/sms4_rk_reverse_buffer.sv
// Round-key store: captures NRK keys from key expansion, replays them forward or reversed.
// Latency: rd_start to the first key is 1 cycle; then one key per cycle, and a 1-cycle bubble between replays.
// Backpressure: wr_ready is low once the store is full; rd_en=0 holds rd_rk/rd_round stable indefinitely.
module sms4_rk_reverse_buffer #(
    parameter int BWIDTH = 32,
    parameter int NRK    = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [BWIDTH-1:0] wr_rk,
    output logic              keys_ready,
    input  logic              rd_start,
    input  logic              rd_decrypt,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [BWIDTH-1:0] rd_rk,
    output logic [AWIDTH-1:0] rd_round,
    output logic              rd_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_IDX   = AWIDTH'(NRK - 1);
    localparam logic [AWIDTH-1:0] PENULT_IDX = AWIDTH'(NRK - 2);

    state_t            state;
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] ridx;
    logic [AWIDTH-1:0] next_ridx;
    logic [AWIDTH-1:0] start_idx;
    logic              rev;
    logic              wr_acc;
    logic [BWIDTH-1:0] mem [NRK];

    // wr_ready is registered and only high in EMPTY/LOADING, so it doubles as the write gate.
    assign wr_acc    = wr_valid && wr_ready;
    assign start_idx = rd_decrypt ? LAST_IDX : '0;
    // Only evaluated while not on the last key, so it stays within 0..NRK-1.
    assign next_ridx = rev ? (ridx - AWIDTH'(1)) : (ridx + AWIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_acc) begin
            mem[wptr] <= wr_rk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= EMPTY;
            wptr       <= '0;
            ridx       <= '0;
            rev        <= 1'b0;
            wr_ready   <= 1'b1;
            keys_ready <= 1'b0;
            rd_valid   <= 1'b0;
            rd_rk      <= '0;
            rd_round   <= '0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                EMPTY, LOADING: begin
                    if (wr_acc) begin
                        if (wptr == LAST_IDX) begin
                            state      <= FULL;
                            wr_ready   <= 1'b0;
                            keys_ready <= 1'b1;
                        end else begin
                            state <= LOADING;
                            wptr  <= wptr + AWIDTH'(1);
                        end
                    end
                end
                FULL: begin
                    if (rd_start) begin
                        state    <= READING;
                        rev      <= rd_decrypt;
                        ridx     <= start_idx;
                        rd_rk    <= mem[start_idx];
                        rd_valid <= 1'b1;
                        busy     <= 1'b1;
                        rd_round <= '0;
                        rd_last  <= (LAST_IDX == '0);
                    end
                end
                READING: begin
                    if (rd_en) begin
                        if (rd_last) begin
                            state    <= FULL;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            busy     <= 1'b0;
                            rd_round <= '0;
                        end else begin
                            ridx     <= next_ridx;
                            rd_rk    <= mem[next_ridx];
                            rd_round <= rd_round + AWIDTH'(1);
                            rd_last  <= (rd_round == PENULT_IDX);
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sms4_rk_reverse_buffer.sv
// Bench for sms4_rk_reverse_buffer: table of load/replay scenarios, hand-written corner sequences, random runs.
module tb_sms4_rk_reverse_buffer;
    localparam int BW  = 32;
    localparam int NRK = 32;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          rst, clear, wr_valid, rd_start, rd_decrypt, rd_en;
    logic [BW-1:0] wr_rk;
    logic          wr_ready, keys_ready, rd_valid, rd_last, busy;
    logic [BW-1:0] rd_rk;
    logic [AW-1:0] rd_round;

    always #5 clk = ~clk;

    sms4_rk_reverse_buffer #(.BWIDTH(BW), .NRK(NRK), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rk(wr_rk),
        .keys_ready(keys_ready),
        .rd_start(rd_start), .rd_decrypt(rd_decrypt), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_rk(rd_rk), .rd_round(rd_round),
        .rd_last(rd_last), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the keys in acceptance order and how many have been accepted.
    logic [BW-1:0] ref_keys [NRK];
    int            model_cnt = 0;

    typedef struct {
        logic [BW-1:0] base;
        bit            dec;
        int            mode;
        logic [BW-1:0] exp_first;
        logic [BW-1:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] exp_key(input bit dec, input int r);
        return dec ? ref_keys[NRK-1-r] : ref_keys[r];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_cnt = 0;
    endtask

    task automatic check_idle_empty(input string tag);
        check({tag, " wr_ready"}, wr_ready, 1);
        check({tag, " keys_ready"}, keys_ready, 0);
        check({tag, " rd_valid"}, rd_valid, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    // Offers n keys; with gaps, wr_valid is randomly dropped. rnd picks fully random key values.
    task automatic load(input logic [BW-1:0] base, input int n, input bit gaps, input bit rnd);
        int sent = 0;
        int cyc  = 0;
        bit v;
        while (sent < n && cyc < 8 * NRK) begin
            v = gaps ? bit'($urandom % 2) : 1'b1;
            check("load wr_ready", wr_ready, model_cnt < NRK);
            check("load keys_ready", keys_ready, model_cnt == NRK);
            wr_valid = v;
            wr_rk    = rnd ? BW'($urandom) : base + BW'(model_cnt);
            tick();
            if (v) begin
                if (model_cnt < NRK) begin
                    ref_keys[model_cnt] = wr_rk;
                    model_cnt++;
                end
                sent++;
            end
            cyc++;
        end
        check("load finished", sent, n);
        wr_valid = 1'b0;
        wr_rk    = '0;
    endtask

    // Starts a replay and consumes all keys. clear_at / restart_at inject clear or an extra
    // rd_start (opposite direction) when that round is on the output; -1 disables.
    task automatic replay(input bit dec, input int mode, input int clear_at, input int restart_at,
                          output logic [BW-1:0] first_rk, output logic [BW-1:0] last_rk);
        int got = 0;
        int cyc = 0;
        bit en;
        first_rk = '0;
        last_rk  = '0;
        rd_start   = 1'b1;
        rd_decrypt = dec;
        tick();
        rd_start   = 1'b0;
        rd_decrypt = 1'b0;
        while (got < NRK && cyc < 6 * NRK) begin
            check("rd_valid", rd_valid, 1);
            if (!rd_valid) break;
            check("rd_round", rd_round, got);
            check("rd_rk", rd_rk, exp_key(dec, got));
            check("rd_last", rd_last, got == NRK - 1);
            check("busy", busy, 1);
            check("keys_ready in replay", keys_ready, 1);
            if (got == 0) first_rk = rd_rk;
            if (got == NRK - 1) last_rk = rd_rk;
            if (got == clear_at) begin
                clear = 1'b1;
                rd_en = 1'b1;
                tick();
                clear = 1'b0;
                rd_en = 1'b0;
                model_cnt = 0;
                check("clear rd_valid", rd_valid, 0);
                check("clear keys_ready", keys_ready, 0);
                check("clear wr_ready", wr_ready, 1);
                check("clear busy", busy, 0);
                return;
            end
            case (mode)
                0:       en = 1'b1;
                1:       en = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: en = bit'($urandom % 2);
            endcase
            rd_en      = en;
            rd_start   = (got == restart_at);
            rd_decrypt = ~dec;
            tick();
            rd_en      = 1'b0;
            rd_start   = 1'b0;
            rd_decrypt = 1'b0;
            if (en) got++;
            cyc++;
        end
        check("replay key count", got, NRK);
        check("end rd_valid", rd_valid, 0);
        check("end rd_last", rd_last, 0);
        check("end busy", busy, 0);
        check("end keys_ready", keys_ready, 1);
        check("end wr_ready", wr_ready, 0);
    endtask

    initial begin
        logic [BW-1:0] f, l;
        rst = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_rk = '0;
        rd_start = 1'b0; rd_decrypt = 1'b0; rd_en = 1'b0;

        vecs[0] = '{32'h1000_0000, 1'b0, 0, 32'h1000_0000, 32'h1000_001F};
        vecs[1] = '{32'h1000_0000, 1'b1, 0, 32'h1000_001F, 32'h1000_0000};
        vecs[2] = '{32'h1000_0000, 1'b1, 1, 32'h1000_001F, 32'h1000_0000};
        vecs[3] = '{32'h2000_0000, 1'b0, 2, 32'h2000_0000, 32'h2000_001F};

        do_reset();
        check_idle_empty("reset");
        check("reset rd_rk", rd_rk, 0);
        check("reset rd_round", rd_round, 0);
        check("reset rd_last", rd_last, 0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            load(vecs[i].base, NRK, 1'b0, 1'b0);
            check("full wr_ready", wr_ready, 0);
            check("full keys_ready", keys_ready, 1);
            replay(vecs[i].dec, vecs[i].mode, -1, -1, f, l);
            check("table first key", f, vecs[i].exp_first);
            check("table last key", l, vecs[i].exp_last);
        end

        // rd_start during LOADING, wr_valid in FULL, rd_start mid-replay, back-to-back replays.
        do_reset();
        load(32'h3000_0000, 10, 1'b0, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("loading start rd_valid", rd_valid, 0);
        check("loading start busy", busy, 0);
        check("loading start wr_ready", wr_ready, 1);
        tick();
        check("loading start rd_valid later", rd_valid, 0);
        load(32'h3000_0000, NRK - 10, 1'b0, 1'b0);
        check("keys_ready after 32", keys_ready, 1);
        wr_valid = 1'b1;
        wr_rk    = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full ignores write", wr_ready, 0);
        end
        wr_valid = 1'b0;
        replay(1'b0, 0, -1, 5, f, l);
        check("after deadbeef first", f, 32'h3000_0000);
        check("after deadbeef last", l, 32'h3000_001F);
        replay(1'b1, 0, -1, -1, f, l);
        check("back-to-back first", f, 32'h3000_001F);
        replay(1'b0, 1, -1, 12, f, l);

        // clear mid-replay then reload
        replay(1'b0, 0, 7, -1, f, l);
        tick();
        check_idle_empty("after clear");
        load(32'h2000_0000, NRK, 1'b0, 1'b0);
        replay(1'b0, 0, -1, -1, f, l);
        check("reload first", f, 32'h2000_0000);
        check("reload last", l, 32'h2000_001F);

        // rst mid-LOADING restarts the write pointer
        do_reset();
        load(32'h4000_0000, 10, 1'b0, 1'b0);
        do_reset();
        check_idle_empty("rst mid-load");
        load(32'h5000_0000, NRK, 1'b0, 1'b0);
        check("rst reload keys_ready", keys_ready, 1);
        replay(1'b0, 0, -1, -1, f, l);
        check("rst reload first", f, 32'h5000_0000);
        check("rst reload last", l, 32'h5000_001F);

        // random keys, gaps on write, random direction and stalls
        for (int k = 0; k < 6; k++) begin
            do_reset();
            load('0, NRK, 1'b1, 1'b1);
            for (int j = 0; j < 3; j++) begin
                replay(bit'($urandom % 2), 2, -1, (j == 1) ? int'($urandom_range(0, NRK - 1)) : -1, f, l);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sms4_rk_reverse_buffer.md
Name: sms4_rk_reverse_buffer

Overview:
- Round-key store between SMS4 key expansion (writer) and the round datapath (reader).
- Captures the 32 round keys in generation order, then replays them:
  - forward (rk0..rk31) for encryption;
  - reversed (rk31..rk0) for decryption.
- Keys are retained after a replay, so back-to-back blocks reuse them without re-expansion.

Parameters:
- BWIDTH, 32, round-key word width.
- NRK, 32, number of round keys stored.
- AWIDTH, 5, index width; must satisfy 2**AWIDTH >= NRK.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- clear  input  1  discard stored keys, return to EMPTY.
- wr_valid  input  1  writer presents a round key.
- wr_ready  output  1  buffer accepts a key this cycle.
- wr_rk  input  BWIDTH  round key from key expansion.
- keys_ready  output  1  all NRK keys are stored.
- rd_start  input  1  begin a replay; sampled only in FULL.
- rd_decrypt  input  1  replay direction, sampled with rd_start; 1 = reverse.
- rd_en  input  1  reader consumes the current key.
- rd_valid  output  1  rd_rk holds a valid key.
- rd_rk  output  BWIDTH  current round key.
- rd_round  output  AWIDTH  round number 0..NRK-1 of the current output, in consumption order.
- rd_last  output  1  current key is the final one of the replay.
- busy  output  1  replay in progress.

Behaviour:
- States: EMPTY, LOADING, FULL, READING.
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset takes priority over everything and gives:
  - state EMPTY;
  - wr_ready=1, keys_ready=0, rd_valid=0, rd_rk=0, rd_round=0, rd_last=0, busy=0;
  - write pointer 0.
  - Storage contents are don't-care.
- clear has the next priority. It behaves as rst except that storage is untouched. It aborts a replay mid-stream; rd_valid is 0 on the next cycle.
- Write path:
  - wr_ready=1 exactly in EMPTY/LOADING.
  - A key is accepted on wr_valid&&wr_ready: it is stored at wptr and wptr increments.
  - The first accept moves EMPTY->LOADING.
  - The accept with wptr==NRK-1 moves to FULL; keys_ready=1 from the next cycle.
  - wr_valid is ignored in FULL/READING.
- Read start:
  - rd_start is honoured only in FULL; it is ignored in all other states, including READING.
  - On rd_start at cycle T, latch rd_decrypt and enter READING.
  - At T+1: rd_valid=1, busy=1, rd_round=0, rd_rk=rk[0] (forward) or rk[NRK-1] (reverse).
  - Start latency is 1 cycle.
- Read advance:
  - On rd_valid&&rd_en, the next key appears on the next cycle.
  - Forward: storage index increments. Reverse: storage index decrements.
  - rd_round increments in both directions.
  - With rd_en=0, outputs hold stable indefinitely.
- Throughput: one key per cycle with rd_en held high.
- Last key:
  - rd_last=1 while rd_round==NRK-1.
  - Consuming that key gives rd_valid=0, rd_last=0, busy=0 next cycle, and state returns to FULL.
  - keys_ready stays 1.
  - The earliest following rd_start is accepted in that same FULL cycle; back-to-back replays have a 1-cycle bubble.
- Storage index arithmetic is within 0..NRK-1 and never wraps. rd_rk is registered; there is no combinational path from rd_en to rd_rk.
- Storage is a register or distributed array: one synchronous write, one synchronous read.

Test Plan:
- Reset/load/forward replay:
  - Stimulus: rst 2 cycles; write rk[i]=32'h1000_0000+i for i=0..31, wr_valid continuous.
  - Required: wr_ready drops and keys_ready=1 the cycle after the 32nd accept.
  - Then rd_start with rd_decrypt=0 and rd_en=1 continuously.
  - Required: rd_rk = 32'h1000_0000..32'h1000_001F on consecutive cycles; rd_last only with 32'h1000_001F; busy low after.
- Reverse replay:
  - Stimulus: same load, then rd_start with rd_decrypt=1.
  - Required: rd_rk = 32'h1000_001F first, down to 32'h1000_0000 with rd_last=1; rd_round runs 0..31.
- Reader stalls:
  - Stimulus: reverse replay with rd_en toggled 1,0,0,1,…
  - Required: rd_rk/rd_round stay frozen during rd_en=0; no key skipped or duplicated; 32 keys delivered total.
- Ignored commands:
  - Stimulus: rd_start asserted while LOADING (after 10 writes), and again mid-READING.
  - Required: the LOADING rd_start gives no rd_valid; the mid-READING rd_start leaves direction and sequence unchanged.
  - Stimulus: wr_valid asserted in FULL with wr_rk=32'hDEAD_BEEF.
  - Required: the next forward replay is unchanged.
- Back-to-back replays:
  - Stimulus: a forward replay, then rd_start in the first FULL cycle with rd_decrypt=1.
  - Required: the reverse sequence starts after exactly a 1-cycle rd_valid=0 bubble; keys_ready stays 1 throughout.
- Clear/rst mid-operation:
  - Stimulus: clear at rd_round==7.
  - Required: next cycle rd_valid=0, keys_ready=0, wr_ready=1.
  - Stimulus: reload with rk[i]=32'h2000_0000+i, forward replay.
  - Required: the new values are output.
  - Stimulus: rst asserted mid-LOADING.
  - Required: the write pointer restarts at 0.
